fmps_write_link: RTL and testbench

FMPS_WRITE_LINK -- requirements
Module: fmps_write_link

---
 rtl/fmps_write_link.sv | 106 ++++++++++
 tb/tb_fmps_write_link.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fmps_write_link.sv
// fmps_write_link: sends a two-word FMPS status packet (header, data) over AXI-Stream on each accepted strobe
module fmps_write_link #(
   parameter int               INDEX_WIDTH = 5,
   parameter logic [15:0]      MARKER      = 16'hF3A5,
   parameter int               COUNT_WIDTH = 16
) (
   input  logic                   auClk,
   input  logic                   auReset,
   input  logic                   auFAstrobe,
   input  logic                   inhibit,
   input  logic [INDEX_WIDTH-1:0] fmpsIndex,
   input  logic                   fmpsEnabled,
   input  logic [31:0]            fmpsData,
   output logic                   TVALID,
   output logic                   TLAST,
   output logic [31:0]            TDATA,
   input  logic                   TREADY,
   output logic                   busy,
   output logic [2:0]             seqno,
   output logic [COUNT_WIDTH-1:0] txCount,
   output logic [COUNT_WIDTH-1:0] overrunCount,
   output logic                   overrunStrobe
);
   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
   state_t                   state_q;
   logic                     tvalid_q, tlast_q, ovr_q;
   logic [31:0]              tdata_q, data_q;
   logic [2:0]               seq_q;
   logic [COUNT_WIDTH-1:0]   tx_q, oc_q;
   logic                     xfer, take;
   logic [2:0]               seq_cap;
   logic [31:0]              hdr;
   // header built from live inputs; only sampled at the capture cycle
   always_comb begin
      xfer    = tvalid_q & TREADY;
      take    = auFAstrobe & ~inhibit;
      seq_cap = (state_q == DATA) ? seq_q + 3'd1 : seq_q;
      hdr     = {MARKER, fmpsEnabled, seq_cap, 12'(fmpsIndex)};
   end
   // packet FSM with registered stream outputs and statistics
   always_ff @(posedge auClk) begin
      if (auReset) begin
         state_q  <= IDLE;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         data_q   <= '0;
         seq_q    <= '0;
         tx_q     <= '0;
         oc_q     <= '0;
         ovr_q    <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (take) begin
                  state_q  <= HEADER;
                  tvalid_q <= 1'b1;
                  tlast_q  <= 1'b0;
                  tdata_q  <= hdr;
                  data_q   <= fmpsData;
               end
            end
            HEADER: begin
               if (auFAstrobe) begin
                  ovr_q <= 1'b1;
                  oc_q  <= oc_q + COUNT_WIDTH'(oc_q != '1);
               end
               if (xfer) begin
                  state_q <= DATA;
                  tlast_q <= 1'b1;
                  tdata_q <= data_q;
               end
            end
            DATA: begin
               if (xfer) begin
                  tx_q  <= tx_q + COUNT_WIDTH'(tx_q != '1);
                  seq_q <= seq_q + 3'd1;
                  state_q  <= take ? HEADER : IDLE;
                  tvalid_q <= take;
                  tlast_q  <= 1'b0;
                  tdata_q  <= take ? hdr : '0;
                  if (take) data_q <= fmpsData;
               end else if (auFAstrobe) begin
                  ovr_q <= 1'b1;
                  oc_q  <= oc_q + COUNT_WIDTH'(oc_q != '1);
               end
            end
            default: begin
               state_q  <= IDLE;
               tvalid_q <= 1'b0;
               tlast_q  <= 1'b0;
               tdata_q  <= '0;
            end
         endcase
      end
   end
   assign TVALID        = tvalid_q;
   assign TLAST         = tlast_q;
   assign TDATA         = tdata_q;
   assign busy          = (state_q != IDLE);
   assign seqno         = seq_q;
   assign txCount       = tx_q;
   assign overrunCount  = oc_q;
   assign overrunStrobe = ovr_q;
endmodule

// File: tb/tb_fmps_write_link.sv
// tb_fmps_write_link: directed checks of the FMPS write link packet sequencing
module tb_fmps_write_link;
   logic        clk = 1'b0;
   logic        rst, strobe, inhibit, en, tready;
   logic [4:0]  idx;
   logic [31:0] data;
   logic        tvalid, tlast, busy, ovs;
   logic [31:0] tdata;
   logic [2:0]  seqno;
   logic [15:0] txc, occ;
   int          n_pass = 0, n_tot = 0;
   logic [31:0] held;
   fmps_write_link dut (
      .auClk(clk), .auReset(rst), .auFAstrobe(strobe), .inhibit(inhibit),
      .fmpsIndex(idx), .fmpsEnabled(en), .fmpsData(data),
      .TVALID(tvalid), .TLAST(tlast), .TDATA(tdata), .TREADY(tready),
      .busy(busy), .seqno(seqno), .txCount(txc), .overrunCount(occ),
      .overrunStrobe(ovs)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1; strobe = 0; inhibit = 0; en = 1; tready = 1; idx = 5; data = 32'h12345678;
      step(); step();
      rst = 0;
      chk("rst_tvalid", 32'(tvalid), 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_seq", 32'(seqno), 0);
      chk("rst_tx", 32'(txc), 0);
      chk("rst_oc", 32'(occ), 0);
      // basic packet
      strobe = 1; step(); strobe = 0;
      chk("p1_tvalid", 32'(tvalid), 1);
      chk("p1_hdr", tdata, 32'hF3A5_8005);
      chk("p1_hlast", 32'(tlast), 0);
      step();
      chk("p1_data", tdata, 32'h12345678);
      chk("p1_dlast", 32'(tlast), 1);
      step();
      chk("p1_idle_tvalid", 32'(tvalid), 0);
      chk("p1_idle_tdata", tdata, 0);
      chk("p1_tx", 32'(txc), 1);
      chk("p1_seq", 32'(seqno), 1);
      // backpressure in HEADER with input changes
      tready = 0; strobe = 1; step(); strobe = 0;
      chk("bp_hdr", tdata, 32'hF3A5_9005);
      idx = 3; en = 0; data = 32'hDEADBEEF; inhibit = 1;
      held = tdata;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold", tdata, held);
         chk("bp_valid", 32'(tvalid), 1);
      end
      // overrun while stalled in HEADER
      inhibit = 0; strobe = 1; step(); strobe = 0;
      chk("ov_pulse", 32'(ovs), 1);
      chk("ov_cnt", 32'(occ), 1);
      chk("ov_hdr", tdata, 32'hF3A5_9005);
      step();
      chk("ov_pulse_end", 32'(ovs), 0);
      tready = 1; step();
      chk("bp_data", tdata, 32'h12345678);
      chk("bp_dlast", 32'(tlast), 1);
      step();
      chk("bp_tx", 32'(txc), 2);
      chk("bp_seq", 32'(seqno), 2);
      // back-to-back strobe on DATA transfer
      idx = 5; en = 1; data = 32'hA5A5A5A5;
      strobe = 1; step(); strobe = 0;
      chk("b2b_hdr1", tdata, 32'hF3A5_A005);
      step();
      chk("b2b_data1", tdata, 32'hA5A5A5A5);
      data = 32'h11112222; strobe = 1; step(); strobe = 0;
      chk("b2b_valid", 32'(tvalid), 1);
      chk("b2b_hdr2", tdata, 32'hF3A5_B005);
      chk("b2b_tx", 32'(txc), 3);
      chk("b2b_ov", 32'(occ), 1);
      step();
      chk("b2b_data2", tdata, 32'h11112222);
      strobe = 1; inhibit = 1; step(); strobe = 0; inhibit = 0;
      chk("inh_end_valid", 32'(tvalid), 0);
      chk("inh_end_busy", 32'(busy), 0);
      chk("inh_end_tx", 32'(txc), 4);
      chk("inh_end_seq", 32'(seqno), 4);
      // wrap of sequence number
      for (int k = 0; k < 5; k++) begin
         strobe = 1; step(); strobe = 0;
         chk("wrap_hdr", tdata, {16'hF3A5, 1'b1, 3'(4 + k), 12'd5});
         step(); step();
         chk("wrap_seq", 32'(seqno), 32'((5 + k) % 8));
      end
      chk("wrap_tx", 32'(txc), 9);
      strobe = 1; inhibit = 1; step(); strobe = 0; inhibit = 0;
      chk("inh_valid", 32'(tvalid), 0);
      chk("inh_tx", 32'(txc), 9);
      chk("inh_seq", 32'(seqno), 1);
      // reset mid-packet
      tready = 0; strobe = 1; step(); strobe = 0;
      tready = 1; step();
      tready = 0; step();
      chk("mid_last", 32'(tlast), 1);
      rst = 1; step(); rst = 0;
      chk("mr_valid", 32'(tvalid), 0);
      chk("mr_seq", 32'(seqno), 0);
      chk("mr_tx", 32'(txc), 0);
      chk("mr_oc", 32'(occ), 0);
      chk("mr_busy", 32'(busy), 0);
      rst = 1; strobe = 1; step(); rst = 0; strobe = 0;
      chk("rst_prio", 32'(busy), 0);
      tready = 1; strobe = 1; step(); strobe = 0;
      chk("post_rst_hdr", tdata, 32'hF3A5_8005);
      step(); step();
      chk("post_rst_tx", 32'(txc), 1);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
